// File: rtl/ring_mon_pkg.sv
// Shared definitions for the ring phase monitor: FSM state encoding,
// default ring geometry and a direction-aware rotate helper.
package ring_mon_pkg;

  localparam int RING_WIDTH       = 8;
  localparam int RING_LOCK_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_t;

  // Rotates the low w bits of s by one position. Bits above w are ignored,
  // so callers zero-extend their ring into the 64-bit container.
  function automatic logic [63:0] ring_rotate(input logic [63:0] s,
                                              input int          w,
                                              input logic        left);
    logic [63:0] mask;
    logic [63:0] sm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sm   = s & mask;
    if (left)
      ring_rotate = ((sm << 1) | (sm >> (w - 1))) & mask;
    else
      ring_rotate = ((sm >> 1) | (sm << (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder. o_valid is high only when exactly
// one input bit is set; o_idx is meaningful only in that case.
module onehot_encoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         i_vec,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int IW = $clog2(WIDTH);

  logic w_seen;
  logic w_multi;

  // OR together the indices of set bits and flag more than one set bit
  always_comb begin
    o_idx   = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        o_idx  = o_idx | IW'(i);
      end
    end
    o_valid = w_seen & ~w_multi;
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: registers the ring counter bus, checks that it stays
// one-hot and rotates one step per clock, reports phase, lock, faults and
// completed revolutions. Latency from count_in to outputs is two edges.
// Build option: define RING_MON_HOLD_EN to tolerate a held one-hot value
// (upstream counter with clock enable) instead of treating it as a fault.
//
// state  | meaning
// IDLE   | waiting for the first one-hot sample (no errors raised)
// TRACK  | counting consecutive correct rotations toward lock
// LOCKED | rotation verified; any bad sample is a fault
// FAULT  | fault seen while locked; waiting for a one-hot sample
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH       = RING_WIDTH,
  parameter int LOCK_CYCLES = RING_LOCK_CYCLES,
  parameter int REV_W       = 8,
  parameter int ROTATE_LEFT = 1
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic [REV_W-1:0]         rev_count
);

  localparam int PW = $clog2(WIDTH);
  localparam int GW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CYCLES - 1);
  localparam logic ROT_L = (ROTATE_LEFT != 0);

  logic [WIDTH-1:0] r_samp;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rot;
  logic [PW-1:0]    w_idx;
  logic             w_onehot;
  logic             w_step_ok;
  logic             w_wrap;
  logic             w_hold;
  logic             w_err_set;

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic [GW-1:0]    r_good;
  logic [GW-1:0]    w_good_nxt;

  logic [PW-1:0]    r_phase;
  logic             r_phase_valid;
  logic             r_err;
  logic             r_err_sticky;
  logic [REV_W-1:0] r_rev;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .i_vec  (r_samp),
    .o_idx  (w_idx),
    .o_valid(w_onehot)
  );

  assign w_rot     = WIDTH'(ring_rotate(64'(r_prev), WIDTH, ROT_L));
  assign w_step_ok = w_onehot && (r_samp == w_rot);
  // A correct step out of the end bit is the only way back to the start bit
  assign w_wrap    = w_step_ok && (ROT_L ? r_prev[WIDTH-1] : r_prev[0]);

`ifdef RING_MON_HOLD_EN
  assign w_hold = w_onehot && (r_samp == r_prev);
`else
  assign w_hold = 1'b0;
`endif

  // Input pipeline: current sample and the one before it
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_samp <= '0;
      r_prev <= '0;
    end else begin
      r_samp <= count_in;
      r_prev <= r_samp;
    end
  end

  // FSM state and lock-qualification counter
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = TRACK;
          w_good_nxt  = '0;
        end
      end
      TRACK: begin
        if (w_step_ok) begin
          if (r_good == GOOD_MAX) begin
            w_state_nxt = LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end else if (w_hold) begin
          w_good_nxt = r_good;
        end else if (w_onehot) begin
          w_good_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if (!w_step_ok && !w_hold) w_state_nxt = FAULT;
      end
      FAULT: begin
        if (w_onehot) begin
          w_state_nxt = TRACK;
          w_good_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs derived from the current state
  always_comb begin
    locked    = (r_state == LOCKED);
    w_err_set = (r_state == LOCKED) && !w_step_ok && !w_hold;
  end

  // Phase, fault flags and revolution counter
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_rev         <= '0;
    end else begin
      r_phase_valid <= w_onehot;
      if (w_onehot) r_phase <= w_idx;
      r_err <= w_err_set;
      if (w_err_set)    r_err_sticky <= 1'b1;
      else if (clr_err) r_err_sticky <= 1'b0;
      if ((r_state == LOCKED) && w_wrap) r_rev <= r_rev + REV_W'(1);
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign err         = r_err;
  assign err_sticky  = r_err_sticky;
  assign rev_count   = r_rev;

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Sits directly downstream of the 8-bit ring counter and consumes its one-hot count bus.
- Checks that the bus is one-hot and rotates by exactly one position per clock.
- Encodes the active bit to a binary phase index and counts completed revolutions.
- Reports lock status and rotation faults to the control/debug logic.

Parameters:
- WIDTH, 8: ring width in bits; must be at least 2.
- LOCK_CYCLES, 4: number of consecutive correct rotations needed to declare lock; must be at least 1.
- REV_W, 8: width of the revolution counter.
- ROTATE_LEFT, 1: 1 = expected next value is {s[WIDTH-2:0], s[WIDTH-1]}; 0 = {s[0], s[WIDTH-1:1]}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- init  in  1  asynchronous active-high reset (same net that initialises the ring counter).
- count_in  in  WIDTH  ring counter output bus.
- clr_err  in  1  synchronous clear of err_sticky.
- phase  out  $clog2(WIDTH)  binary index of the active bit.
- phase_valid  out  1  last evaluated sample was one-hot.
- locked  out  1  high while in the LOCKED state.
- err  out  1  one-cycle pulse on a rotation fault while LOCKED.
- err_sticky  out  1  latched fault flag.
- rev_count  out  REV_W  completed revolutions while LOCKED.

Behaviour:
- Reset (init=1, asynchronous): all internal registers and outputs go to 0; state = IDLE.
- Pipeline:
  - Edge k: count_in is registered into samp; the old samp moves into prev.
  - Edge k+1: checks on samp/prev update state and all outputs.
  - Total latency from count_in to outputs is 2 edges.
- Per-cycle checks on samp:
  - onehot = exactly one bit set.
  - step_ok = onehot && samp == rot(prev), where rot() follows ROTATE_LEFT.
  - wrap = step_ok && transition is bit WIDTH-1 -> bit 0 (left), or bit 0 -> bit WIDTH-1 (right).
- phase / phase_valid:
  - If onehot: phase = index of the set bit and phase_valid = 1.
  - Otherwise phase holds its last value and phase_valid = 0.
- FSM, with good_cnt counting 0..LOCK_CYCLES-1:
  - IDLE: onehot -> TRACK with good_cnt = 0; else stay. Never flags errors (covers all-zero or X bus before upstream init).
  - TRACK:
    - step_ok: if good_cnt == LOCK_CYCLES-1 -> LOCKED, else good_cnt++.
    - onehot && !step_ok: stay, good_cnt = 0.
    - !onehot: -> IDLE.
  - LOCKED: step_ok -> stay; any other sample -> FAULT, with err = 1 for that cycle and err_sticky set.
  - FAULT: onehot -> TRACK with good_cnt = 0; else stay.
- locked = (state == LOCKED), registered.
- rev_count:
  - Increments on wrap only while the state is LOCKED before the edge, so the locking step itself is not counted.
  - Wraps modulo 2^REV_W.
  - Not cleared by a fault; cleared only by init.
- err_sticky:
  - Set on any err.
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
- Held value (samp == prev) is a fault (see Optional Feature).
- Asserting init mid-operation returns everything to reset values immediately; relocking needs the full LOCK_CYCLES sequence again.

Optional Feature:
- Macro: RING_MON_HOLD_EN.
- Defined:
  - samp == prev with onehot is tolerated. The state holds, good_cnt does not advance, and no err is raised.
  - Supports an upstream counter with a clock enable.
- Undefined: a held value is treated as !step_ok.

Decomposition:
- Shared package ring_mon_pkg holds:
  - state enum {IDLE, TRACK, LOCKED, FAULT}, 2 bits;
  - default constants RING_WIDTH = 8 and RING_LOCK_CYCLES = 4;
  - a rotate function parameterised by direction.
- One combinational sub-module, onehot_encoder: WIDTH-bit input -> index and one-hot-valid outputs. Instantiated once on samp.

Test Plan:
- Reset and lock: pulse init; feed 01,02,04,08,10,20,40,80,01,... (ROTATE_LEFT=1, LOCK_CYCLES=4). Required:
  - locked rises on the edge after the 5th sample is registered;
  - phase follows 0..7 with a 2-edge lag;
  - err and err_sticky stay 0.
- Revolutions: run locked for 3 full laps (24 samples). Required: rev_count = 3, incrementing at each 80 -> 01 step.
- Skip fault: while locked, inject 04 -> 10. Required:
  - err pulses for exactly 1 cycle and err_sticky = 1;
  - locked falls and the FSM enters FAULT;
  - after 5 good samples locked returns;
  - rev_count is unchanged by the fault.
- Non-one-hot: inject 0x03 while locked. Required: phase_valid = 0, phase holds its previous value, err pulses, state goes to FAULT.
- Clear priority: assert clr_err alone, then assert clr_err in the same cycle as a new fault. Required: err_sticky goes 1->0 first, then stays 1.
- Hold and mid-run init: repeat 08 twice.
  - Without RING_MON_HOLD_EN: err fires.
  - With RING_MON_HOLD_EN: no err and locked stays 1.
  - Then assert init asynchronously between edges. Required: all outputs 0 immediately.
